// File: rtl/aes_sub_bytes_iter.sv
`default_nettype none
// ============================================================================
// Module      : aes_sbox_lut / aes_sub_bytes_iter
// Description : Iterative AES SubBytes stage. NumSbox byte-wide S-box lanes
//               are reused over 16/NumSbox passes. The stage has valid/ready
//               handshakes on both sides, captures the mode once per block,
//               and supports a synchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// Single-byte forward/inverse AES S-box.
// The S-box is computed as a GF(2^8) inverse plus an affine transform rather
// than stored as a 256-entry table, so one lane serves both directions.
// ----------------------------------------------------------------------------
module aes_sbox_lut (
    input  logic       inv_i,
    input  logic [7:0] data_i,
    output logic [7:0] data_o
);

    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0, as AES requires)
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] y;
        logic [7:0] r;
        y = a;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            y = gf_mul(y, y);
            r = gf_mul(r, y);
        end
        return r;
    endfunction

    logic [7:0] w_pre;
    logic [7:0] w_inv;
    logic [7:0] w_fwd;

    // Inverse affine transform, applied before inversion in the inverse path
    assign w_pre = inv_i ? ({data_i[6:0], data_i[7]}   ^
                            {data_i[4:0], data_i[7:5]} ^
                            {data_i[1:0], data_i[7:2]} ^ 8'h05)
                         : data_i;

    assign w_inv = gf_inv(w_pre);

    // Forward affine transform, applied after inversion in the forward path
    assign w_fwd = w_inv ^
                   {w_inv[6:0], w_inv[7]}   ^
                   {w_inv[5:0], w_inv[7:6]} ^
                   {w_inv[4:0], w_inv[7:5]} ^
                   {w_inv[3:0], w_inv[7:4]} ^ 8'h63;

    assign data_o = inv_i ? w_inv : w_fwd;

endmodule

// ----------------------------------------------------------------------------
// Iterative SubBytes stage
// ----------------------------------------------------------------------------
module aes_sub_bytes_iter #(
    parameter int NumSbox = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clear_i,
    input  logic         mode_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [127:0] data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [127:0] data_o,
    output logic         busy_o
);

    localparam int Passes = 16 / NumSbox;
    localparam int CNT_W  = (Passes > 1) ? $clog2(Passes) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(Passes - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    if (!(NumSbox == 1 || NumSbox == 2 || NumSbox == 4 ||
          NumSbox == 8 || NumSbox == 16)) begin : g_bad_numsbox
        $error("aes_sub_bytes_iter: NumSbox must be 1, 2, 4, 8 or 16");
    end

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [127:0]     data_q, data_d;
    logic             mode_q, mode_d;

    logic [3:0]       w_idx      [NumSbox];
    logic [7:0]       w_lane_in  [NumSbox];
    logic [7:0]       w_lane_out [NumSbox];
    logic [127:0]     w_busy_data;
    logic             w_accept;

    // Each lane addresses byte cnt*NumSbox + lane of the working register
    for (genvar g = 0; g < NumSbox; g++) begin : g_lane
        assign w_idx[g]     = 4'(32'(cnt_q) * NumSbox + g);
        assign w_lane_in[g] = data_q[{w_idx[g], 3'b000} +: 8];

        aes_sbox_lut u_sbox (
            .inv_i  (mode_q),
            .data_i (w_lane_in[g]),
            .data_o (w_lane_out[g])
        );
    end

    // Write the lane results back in place; untouched bytes pass through
    always_comb begin
        w_busy_data = data_q;
        for (int l = 0; l < NumSbox; l++) begin
            w_busy_data[{w_idx[l], 3'b000} +: 8] = w_lane_out[l];
        end
    end

    assign in_ready_o  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready_i);
    assign w_accept    = in_valid_i && in_ready_o;
    assign out_valid_o = (state_q == ST_DONE);
    assign busy_o      = (state_q == ST_BUSY);
    assign data_o      = data_q;

    // Next-state logic: load on input handshake, iterate passes, hold in DONE
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        mode_d  = mode_q;
        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    data_d  = data_i;
                    mode_d  = mode_i;
                    cnt_d   = '0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                data_d = w_busy_data;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready_i) begin
                    if (in_valid_i) begin
                        data_d  = data_i;
                        mode_d  = mode_i;
                        cnt_d   = '0;
                        state_d = ST_BUSY;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers; reset and clear both discard any block in flight
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            mode_q  <= mode_d;
        end
    end

endmodule
`default_nettype wire

// File: doc/aes_sub_bytes_iter.md
Name: aes_sub_bytes_iter

Overview:
Iterative, parametrised SubBytes unit for the AES cipher core.
- Transforms one 128-bit state block through the forward or inverse S-box.
- Uses NumSbox byte-wide aes_sbox_lut instances and reuses them over 16/NumSbox passes, trading latency for area.
- Adds a valid/ready handshake on both sides, a captured per-block mode, and a synchronous clear. This makes it a drop-in sequential stage between the cipher control FSM and ShiftRows.

Parameters:
NumSbox, 4, number of S-box lanes instantiated; legal values 1, 2, 4, 8, 16; any other value is an elaboration-time error.
Passes, 16/NumSbox, derived localparam giving the number of S-box passes per block; not overridable.

Ports:
clk_i  input  1  clock; all state updates on the rising edge
rst_i  input  1  reset; synchronous and active-high
clear_i  input  1  synchronous abort; same effect as rst_i, but rst_i has priority
mode_i  input  1  0 = forward S-box (cipher), 1 = inverse S-box; sampled only on input handshake
in_valid_i  input  1  data_i and mode_i are valid
in_ready_o  output  1  block can accept a new input this cycle
data_i  input  128  input state; byte j is data_i[8j+:8]
out_valid_o  output  1  data_o holds a finished block
out_ready_i  input  1  downstream accepts data_o this cycle
data_o  output  128  substituted state; byte j is data_o[8j+:8]
busy_o  output  1  high in BUSY state

Behaviour:
Reset and clear:
- rst_i or clear_i high at a rising edge sets: state IDLE, pass counter 0, data register 0, captured mode 0.
- After reset: out_valid_o=0, busy_o=0, data_o=0, in_ready_o=1.
- Reset or clear in any state, including mid-BUSY or during DONE with out_valid_o high, discards the block; no output handshake occurs.

FSM states:
- IDLE: in_ready_o=1.
  - in_valid_i=1: load data_i into the working register, capture mode_i, clear the pass counter, go to BUSY.
- BUSY: in_ready_o=0, out_valid_o=0.
  - Each cycle, lanes L=0..NumSbox-1 substitute byte j = cnt*NumSbox + L and write the result back in place.
  - The counter increments each cycle.
  - When cnt = Passes-1, the last pass writes back and the FSM goes to DONE.
- DONE: out_valid_o=1; data_o is stable and equals the working register.
  - out_ready_i=1 and in_valid_i=0: go to IDLE.
  - out_ready_i=1 and in_valid_i=1: back-to-back. Complete the output handshake and accept the new block in the same cycle (in_ready_o=1), then go to BUSY with the new data.
  - out_ready_i=0: hold; in_ready_o=0; data_o and out_valid_o stay unchanged.

Handshake rules:
- in_ready_o = (state==IDLE) || (state==DONE && out_ready_i). This is the only combinational input-to-output path.
- in_valid_i with in_ready_o=0 is ignored. The upstream must hold it; no internal buffering beyond one block.
- A change of mode_i while BUSY has no effect; the captured mode governs every pass of the block.

Latency and throughput:
- The input handshake occurs at edge E0. busy_o is high for exactly Passes cycles. out_valid_o rises in the cycle after edge E0+Passes.
- NumSbox=16 gives 1 BUSY cycle.
- Sustained throughput with out_ready_i=1 is one block per Passes+1 cycles.

Data rules:
- Bytes not addressed in the current pass are unchanged.
- Every byte is substituted exactly once per block.
- data_o reflects the working register in all states, but is meaningful only while out_valid_o=1.

Test Plan:
- NumSbox=4, mode 0, data_i=128'h0, out_ready_i=1 -> busy_o high for 4 cycles; out_valid_o on the 5th cycle after accept; data_o=128'h6363...63 (all 16 bytes 0x63).
- NumSbox=1, mode 1, data_i all bytes 0x63 -> 16 BUSY cycles; data_o=128'h0. Also check byte 0x16 -> 0xFF and byte 0xED -> 0x53 under the inverse S-box.
- NumSbox=16, mode 0, data_i byte0=0x19, byte1=0x53, rest 0x00 -> 1 BUSY cycle; data_o byte0=0xD4, byte1=0xED, rest 0x63.
- Backpressure: hold out_ready_i=0 for 10 cycles in DONE while toggling in_valid_i and mode_i -> in_ready_o=0, data_o and out_valid_o stable. Then raise out_ready_i with in_valid_i=1 -> output and input handshakes both occur in the same cycle; the next block enters BUSY.
- Mode capture: accept a block with mode_i=0, then drive mode_i=1 during BUSY -> result equals the forward S-box of every byte.
- Assert clear_i on the 2nd BUSY cycle (NumSbox=2) -> next cycle IDLE, in_ready_o=1, out_valid_o=0, data_o=0, no output handshake. Repeat with rst_i during DONE -> same response.
